fir_sample_tx: RTL and testbench

//  Source-side sample transmitter for the FIR datapath's load_in/data_in interface.
//  - Accepts samples from an upstream valid/ready stream and buffers them in a small FIFO.
//  - Presents each sample on data_out with a stretched load_out strobe.
//  - Holds the sample long enough for the filter's load synchronizer and 4-tap MAC sweep.
//  - Sits in the sample-producer clock domain; load_out crosses to the filter via its synchronizer.

---
 rtl/fir_sample_tx.sv | 146 ++++++++++++++
 tb/tb_fir_sample_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_tx.sv
// Sample transmitter feeding the FIR load_in/data_in interface: buffers upstream samples
// in a small FIFO and presents each one with a setup / stretched strobe / hold sequence.
module fir_sample_tx #(
   parameter int DATA_WIDTH   = 12,
   parameter int FIFO_DEPTH   = 4,
   parameter int SETUP_CYCLES = 1,
   parameter int PULSE_CYCLES = 3,
   parameter int HOLD_CYCLES  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          s_valid,
   input  logic [DATA_WIDTH-1:0]         s_data,
   output logic                          s_ready,
   input  logic                          flush,
   output logic                          load_out,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int LW      = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_MAX = (SETUP_CYCLES > PULSE_CYCLES) ?
                            ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                            ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [LW-1:0]         r_level;
   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic                  r_load_out;
   logic [DATA_WIDTH-1:0] r_data_out;

   state_t                w_state_next;
   logic [CW-1:0]         w_cnt_next;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_avail;

   assign s_ready    = (r_level != LW'(FIFO_DEPTH));
   assign w_push     = s_valid && s_ready && !flush;
   // A flush hides the buffered samples from the FSM in the same cycle it clears them.
   assign w_avail    = (r_level != '0) && !flush;
   assign load_out   = r_load_out;
   assign data_out   = r_data_out;
   assign busy       = (r_state != ST_IDLE);
   assign fifo_level = r_level;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (flush) begin
         r_rd_ptr <= r_wr_ptr;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_pop        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_avail) begin
               w_pop        = 1'b1;
               w_cnt_next   = SETUP_LD;
               w_state_next = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (r_cnt == '0) begin
               w_cnt_next   = PULSE_LD;
               w_state_next = ST_STROBE;
            end else begin
               w_cnt_next = r_cnt - CW'(1);
            end
         end
         ST_STROBE: begin
            if (r_cnt == '0) begin
               w_cnt_next   = HOLD_LD;
               w_state_next = ST_HOLD;
            end else begin
               w_cnt_next = r_cnt - CW'(1);
            end
         end
         ST_HOLD: begin
            if (r_cnt == '0) begin
               // Chain straight into the next sample so back-to-back traffic has no IDLE gap.
               if (w_avail) begin
                  w_pop        = 1'b1;
                  w_cnt_next   = SETUP_LD;
                  w_state_next = ST_SETUP;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end else begin
               w_cnt_next = r_cnt - CW'(1);
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_load_out <= 1'b0;
         r_data_out <= '0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_load_out <= (w_state_next == ST_STROBE);
         if (w_pop) begin
            r_data_out <= r_mem[r_rd_ptr];
         end
      end
   end

endmodule

// File: tb/tb_fir_sample_tx.sv
// Directed bench for fir_sample_tx at default parameters: strobe timing, back-pressure,
// flush, push/pop at near-full, async reset and bit-exact pass-through.
module tb_fir_sample_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid;
   logic [11:0] s_data;
   logic        s_ready;
   logic        flush;
   logic        load_out;
   logic [11:0] data_out;
   logic        busy;
   logic [2:0]  fifo_level;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic prev_load = 1'b0;
   int run_len = 0;
   int          q_rise_cyc[$];
   logic [11:0] q_rise_data[$];
   int          q_len[$];

   fir_sample_tx dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .flush(flush), .load_out(load_out), .data_out(data_out), .busy(busy),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then sample just after it and log strobe rises and widths.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (load_out && !prev_load) begin
         q_rise_cyc.push_back(cyc);
         q_rise_data.push_back(data_out);
      end
      if (load_out) run_len++;
      else if (prev_load) begin
         q_len.push_back(run_len);
         run_len = 0;
      end
      prev_load = load_out;
   endtask

   task automatic clear_log();
      q_rise_cyc.delete();
      q_rise_data.delete();
      q_len.delete();
      run_len = 0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 100; i++) begin
         if (!busy && fifo_level == 3'd0) break;
         tick();
      end
      check({tag, "_drain_idle"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic check_seq(input string tag, input logic [11:0] exp_q[$]);
      check({tag, "_npulses"}, q_rise_data.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < q_rise_data.size(); i++) begin
         check($sformatf("%s_data%0d", tag, i), q_rise_data[i], exp_q[i]);
         if (i < q_len.size()) check($sformatf("%s_width%0d", tag, i), q_len[i], 3);
         if (i > 0) check($sformatf("%s_period%0d", tag, i),
                          q_rise_cyc[i] - q_rise_cyc[i-1], 8);
      end
   endtask

   initial begin
      logic [11:0] exp_q[$];
      int idx;
      int accepted;
      bit stall_seen;
      bit acc;

      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; flush = 1'b0;
      repeat (3) tick();
      check("rst_load", {31'd0, load_out}, 32'd0);
      check("rst_data", {20'd0, data_out}, 32'd0);
      check("rst_level", {29'd0, fifo_level}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("rel_ready", {31'd0, s_ready}, 32'd1);
      check("rel_busy", {31'd0, busy}, 32'd0);

      // Single sample: pushed at edge N, data at N+1, strobe N+2..N+4, idle at N+9.
      s_valid = 1'b1; s_data = 12'h400;
      tick();
      s_valid = 1'b0;
      check("t1_level_after_push", {29'd0, fifo_level}, 32'd1);
      check("t1_no_fallthrough", {20'd0, data_out}, 32'd0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("t1_load_N%0d", k), {31'd0, load_out}, {31'd0, (k >= 2 && k <= 4)});
         check($sformatf("t1_busy_N%0d", k), {31'd0, busy}, {31'd0, (k <= 8)});
         check($sformatf("t1_data_N%0d", k), {20'd0, data_out}, 32'h400);
      end

      // Back-to-back stream with back-pressure.
      clear_log();
      idx = 1; accepted = 0; stall_seen = 1'b0;
      for (int g = 0; g < 40 && idx <= 6; g++) begin
         s_valid = 1'b1; s_data = 12'(idx);
         if (!s_ready && !stall_seen) begin
            stall_seen = 1'b1;
            check("t2_accepted_before_stall", accepted, 5);
            check("t2_level_full", {29'd0, fifo_level}, 32'd4);
         end
         acc = s_ready;
         tick();
         if (acc) begin
            idx++;
            accepted++;
         end
      end
      s_valid = 1'b0;
      check("t2_stall_seen", {31'd0, stall_seen}, 32'd1);
      drain("t2");
      exp_q = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006};
      check_seq("t2", exp_q);

      // Flush during the strobe of A with three samples queued.
      clear_log();
      s_valid = 1'b1; s_data = 12'h0A1; tick();
      s_data = 12'h0B2; tick();
      s_data = 12'h0C3; tick();
      check("t3_strobe_started", {31'd0, load_out}, 32'd1);
      s_data = 12'h0D4; tick();
      check("t3_level_before_flush", {29'd0, fifo_level}, 32'd3);
      flush = 1'b1; s_data = 12'h0E5; tick();
      flush = 1'b0; s_valid = 1'b0;
      check("t3_level_flushed", {29'd0, fifo_level}, 32'd0);
      check("t3_load_still_high", {31'd0, load_out}, 32'd1);
      drain("t3");
      repeat (10) tick();
      exp_q = '{12'h0A1};
      check_seq("t3", exp_q);
      check("t3_level_end", {29'd0, fifo_level}, 32'd0);
      check("t3_data_held", {20'd0, data_out}, 32'h0A1);

      // Push coinciding with the HOLD-exit pop while three samples are buffered.
      clear_log();
      s_valid = 1'b1; s_data = 12'h111; tick();
      s_data = 12'h222; tick();
      s_data = 12'h333; tick();
      s_data = 12'h444; tick();
      s_valid = 1'b0;
      repeat (5) tick();
      check("t4_level_pre", {29'd0, fifo_level}, 32'd3);
      check("t4_data_pre", {20'd0, data_out}, 32'h111);
      s_valid = 1'b1; s_data = 12'h555; tick();
      s_valid = 1'b0;
      check("t4_level_same", {29'd0, fifo_level}, 32'd3);
      check("t4_data_popped", {20'd0, data_out}, 32'h222);
      drain("t4");
      exp_q = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
      check_seq("t4", exp_q);

      // Asynchronous reset in the middle of a strobe.
      s_valid = 1'b1; s_data = 12'h123; tick();
      s_data = 12'h456; tick();
      s_valid = 1'b0; tick();
      check("t5_in_strobe", {31'd0, load_out}, 32'd1);
      check("t5_level_pre", {29'd0, fifo_level}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_load", {31'd0, load_out}, 32'd0);
      check("t5_async_data", {20'd0, data_out}, 32'd0);
      check("t5_async_level", {29'd0, fifo_level}, 32'd0);
      check("t5_async_busy", {31'd0, busy}, 32'd0);
      tick();
      rst_n = 1'b1;
      clear_log();
      s_valid = 1'b1; s_data = 12'h7FF; tick();
      s_data = 12'h800; tick();
      s_valid = 1'b0;
      check("t5_recover_data", {20'd0, data_out}, 32'h7FF);
      drain("t5");
      exp_q = '{12'h7FF, 12'h800};
      check_seq("t5", exp_q);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
